// File: rtl/uart_rx_fifo.sv
// UART receiver (configurable frame, glitch reject, break hold-off) feeding a show-ahead receive FIFO.
// A clean word lands in the FIFO the cycle after its last stop sample; FE/PE/OVF are one-cycle pulses.
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 24,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic                          RX,
   input  logic                          Enable,
   output logic [DATA_BITS-1:0]          Data,
   output logic                          Valid,
   input  logic                          Ready,
   output logic [$clog2(FIFO_DEPTH):0]   Count,
   output logic                          FE,
   output logic                          PE,
   output logic                          OVF
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT/2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]    DB_M1   = 4'(DATA_BITS - 1);
   localparam logic [3:0]    SB_M1   = 4'(STOP_BITS - 1);
   localparam logic [AW:0]   DEPTH   = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

   state_t               state, state_nxt;
   logic                 rx_meta, rxs;
   logic [CW-1:0]        clk_cnt;
   logic [3:0]           bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 perr, ferr;
   logic                 tick, frame_done, ferr_now, par_x, par_bad;
   logic                 push_req;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic                 pop, full, wr_en;

   assign tick     = (clk_cnt == FULL_M1);
   assign ferr_now = ferr | ~rxs;
   assign par_x    = (^shreg) ^ rxs;
   assign par_bad  = (PARITY == 2) ? ~par_x : par_x;

   always_ff @(posedge Clk) begin
      if (Reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      frame_done = 1'b0;
      case (state)
         S_IDLE:   if (Enable && !rxs) state_nxt = S_START;
         S_START:  if (clk_cnt == HALF_M1) state_nxt = rxs ? S_IDLE : S_DATA;
         S_DATA:   if (tick && bit_cnt == DB_M1) state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
         S_PARITY: if (tick) state_nxt = S_STOP;
         S_STOP: begin
            if (tick && bit_cnt == SB_M1) begin
               frame_done = 1'b1;
               // a low final stop sample means the line may be in break
               state_nxt  = rxs ? S_IDLE : S_BREAK;
            end
         end
         S_BREAK:  if (rxs) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         rx_meta  <= 1'b1;
         rxs      <= 1'b1;
         clk_cnt  <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         perr     <= 1'b0;
         ferr     <= 1'b0;
         FE       <= 1'b0;
         PE       <= 1'b0;
         push_req <= 1'b0;
      end else begin
         rx_meta  <= RX;
         rxs      <= rx_meta;
         FE       <= 1'b0;
         PE       <= 1'b0;
         push_req <= 1'b0;
         case (state)
            S_IDLE: begin
               clk_cnt <= '0;
               bit_cnt <= '0;
               perr    <= 1'b0;
               ferr    <= 1'b0;
            end
            S_START: clk_cnt <= (clk_cnt == HALF_M1) ? '0 : clk_cnt + 1'b1;
            S_DATA: begin
               if (tick) begin
                  clk_cnt <= '0;
                  shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                  bit_cnt <= (bit_cnt == DB_M1) ? '0 : bit_cnt + 1'b1;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            S_PARITY: begin
               if (tick) begin
                  clk_cnt <= '0;
                  perr    <= par_bad;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (tick) begin
                  clk_cnt <= '0;
                  bit_cnt <= bit_cnt + 1'b1;
                  ferr    <= ferr_now;
                  if (frame_done) begin
                     FE       <= ferr_now;
                     PE       <= perr;
                     push_req <= ~ferr_now & ~perr;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign pop   = Valid & Ready;
   assign full  = (Count == DEPTH);
   assign wr_en = push_req & (~full | pop);
   assign Valid = (Count != '0);
   assign Data  = mem[rd_ptr];

   always_ff @(posedge Clk) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         Count  <= '0;
         OVF    <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         OVF <= push_req & full & ~pop;
         if (wr_en) begin
            mem[wr_ptr] <= shreg;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         Count <= Count + (AW+1)'(wr_en) - (AW+1)'(pop);
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: default, even-parity and odd-parity/7-bit instances driven by bit-level
// serial stimulus; received words are checked against per-instance expected-word queues.
module tb_uart_rx_fifo;

   localparam int C = 24;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] rx;
   logic       en;
   logic [2:0] rdy;
   logic [2:0] vld, fe, pe, ovf;
   logic [7:0] data0, data1;
   logic [6:0] data2;
   logic [2:0] cnt0, cnt1, cnt2;

   int n_cmp = 0;
   int n_fail = 0;
   int fe_n[3], pe_n[3], ovf_n[3];
   logic [8:0] q0[$], q1[$], q2[$];

   always #5 clk = ~clk;

   uart_rx_fifo dut0 (
      .Clk(clk), .Reset(reset), .RX(rx[0]), .Enable(en), .Data(data0), .Valid(vld[0]),
      .Ready(rdy[0]), .Count(cnt0), .FE(fe[0]), .PE(pe[0]), .OVF(ovf[0]));

   uart_rx_fifo #(.PARITY(1)) dut1 (
      .Clk(clk), .Reset(reset), .RX(rx[1]), .Enable(en), .Data(data1), .Valid(vld[1]),
      .Ready(rdy[1]), .Count(cnt1), .FE(fe[1]), .PE(pe[1]), .OVF(ovf[1]));

   uart_rx_fifo #(.PARITY(2), .DATA_BITS(7)) dut2 (
      .Clk(clk), .Reset(reset), .RX(rx[2]), .Enable(en), .Data(data2), .Valid(vld[2]),
      .Ready(rdy[2]), .Count(cnt2), .FE(fe[2]), .PE(pe[2]), .OVF(ovf[2]));

   initial begin
      for (int i = 0; i < 3; i++) begin
         fe_n[i] = 0; pe_n[i] = 0; ovf_n[i] = 0;
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (fe[i])  fe_n[i]++;
         if (pe[i])  pe_n[i]++;
         if (ovf[i]) ovf_n[i]++;
      end
   end

   function automatic int get_count(input int sel);
      case (sel)
         0:       return int'(cnt0);
         1:       return int'(cnt1);
         default: return int'(cnt2);
      endcase
   endfunction

   function automatic logic [8:0] get_data(input int sel);
      case (sel)
         0:       return {1'b0, data0};
         1:       return {1'b0, data1};
         default: return {2'b0, data2};
      endcase
   endfunction

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_bit(input int sel, input logic b);
      rx[sel] = b;
      repeat (C) @(negedge clk);
   endtask

   task automatic send_frame(input int sel, input logic [8:0] d, input int nd,
                             input bit has_par, input logic pbit, input logic stopb);
      drive_bit(sel, 1'b0);
      for (int i = 0; i < nd; i++) drive_bit(sel, d[i]);
      if (has_par) drive_bit(sel, pbit);
      drive_bit(sel, stopb);
   endtask

   task automatic pop_check(input int sel);
      int w = 0;
      logic [8:0] exp_w;
      while (!vld[sel] && w < 100) begin
         @(negedge clk);
         w++;
      end
      n_cmp++;
      if (!vld[sel]) begin
         $display("FAIL pop_valid[%0d]: Valid=%0b after %0d cycles, required 1", sel, vld[sel], w);
         n_fail++;
         return;
      end
      if (sel == 0)      exp_w = (q0.size() > 0) ? q0.pop_front() : 9'h1ff;
      else if (sel == 1) exp_w = (q1.size() > 0) ? q1.pop_front() : 9'h1ff;
      else               exp_w = (q2.size() > 0) ? q2.pop_front() : 9'h1ff;
      n_cmp++;
      if (get_data(sel) !== exp_w) begin
         $display("FAIL pop_data[%0d]: got %h, required %h", sel, get_data(sel), exp_w);
         n_fail++;
      end
      rdy[sel] = 1'b1;
      @(negedge clk);
      rdy[sel] = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      wait_cycles(3);
      n_cmp++;
      if (cnt0 !== 3'd0 || vld[0] !== 1'b0) begin
         $display("FAIL reset_fifo: Count=%0d Valid=%0b, required 0 0", cnt0, vld[0]);
         n_fail++;
      end
      n_cmp++;
      if (data0 !== 8'h00) begin
         $display("FAIL reset_data: got %h, required 00", data0);
         n_fail++;
      end
      n_cmp++;
      if (fe !== 3'b000 || pe !== 3'b000 || ovf !== 3'b000) begin
         $display("FAIL reset_flags: FE=%b PE=%b OVF=%b, required 000", fe, pe, ovf);
         n_fail++;
      end
      reset = 1'b0;
      wait_cycles(2);
   endtask

   task automatic test_single();
      int f0 = fe_n[0], p0 = pe_n[0], o0 = ovf_n[0];
      send_frame(0, 9'h055, 8, 0, 1'b0, 1'b1);
      q0.push_back(9'h055);
      wait_cycles(4);
      n_cmp++;
      if (vld[0] !== 1'b1 || cnt0 !== 3'd1) begin
         $display("FAIL single_count: Valid=%0b Count=%0d, required 1 1", vld[0], cnt0);
         n_fail++;
      end
      n_cmp++;
      if (fe_n[0] != f0 || pe_n[0] != p0 || ovf_n[0] != o0) begin
         $display("FAIL single_flags: FE/PE/OVF pulses %0d/%0d/%0d, required 0/0/0",
                  fe_n[0]-f0, pe_n[0]-p0, ovf_n[0]-o0);
         n_fail++;
      end
      pop_check(0);
      n_cmp++;
      if (vld[0] !== 1'b0 || cnt0 !== 3'd0) begin
         $display("FAIL single_pop: Valid=%0b Count=%0d, required 0 0", vld[0], cnt0);
         n_fail++;
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes[4] = '{8'h55, 8'hA3, 8'hFF, 8'h00};
      int o0;
      for (int i = 0; i < 4; i++) begin
         send_frame(0, {1'b0, bytes[i]}, 8, 0, 1'b0, 1'b1);
         q0.push_back({1'b0, bytes[i]});
      end
      wait_cycles(4);
      n_cmp++;
      if (get_count(0) != 4) begin
         $display("FAIL b2b_count: Count=%0d, required 4", get_count(0));
         n_fail++;
      end
      o0 = ovf_n[0];
      send_frame(0, 9'h012, 8, 0, 1'b0, 1'b1);
      wait_cycles(4);
      n_cmp++;
      if (ovf_n[0] - o0 != 1) begin
         $display("FAIL ovf_pulse: %0d pulses, required 1", ovf_n[0] - o0);
         n_fail++;
      end
      n_cmp++;
      if (get_count(0) != 4) begin
         $display("FAIL ovf_count: Count=%0d, required 4", get_count(0));
         n_fail++;
      end
      for (int i = 0; i < 4; i++) pop_check(0);
      n_cmp++;
      if (vld[0] !== 1'b0) begin
         $display("FAIL b2b_drain: Valid=%0b, required 0", vld[0]);
         n_fail++;
      end
   endtask

   task automatic test_break();
      int f0 = fe_n[0], p0 = pe_n[0];
      send_frame(0, 9'h0A3, 8, 0, 1'b0, 1'b0);
      wait_cycles(3 * C);
      n_cmp++;
      if (fe_n[0] - f0 != 1) begin
         $display("FAIL break_fe: %0d FE pulses, required 1", fe_n[0] - f0);
         n_fail++;
      end
      n_cmp++;
      if (get_count(0) != 0) begin
         $display("FAIL break_count: Count=%0d, required 0", get_count(0));
         n_fail++;
      end
      rx[0] = 1'b1;
      wait_cycles(C);
      send_frame(0, 9'h03C, 8, 0, 1'b0, 1'b1);
      q0.push_back(9'h03C);
      wait_cycles(4);
      pop_check(0);
      n_cmp++;
      if (fe_n[0] - f0 != 1 || pe_n[0] != p0) begin
         $display("FAIL break_after: FE=%0d PE=%0d pulses, required 1 0", fe_n[0] - f0, pe_n[0] - p0);
         n_fail++;
      end
   endtask

   task automatic test_parity();
      int p1 = pe_n[1], f1 = fe_n[1];
      send_frame(1, 9'h0A3, 8, 1, 1'b0, 1'b1);
      q1.push_back(9'h0A3);
      wait_cycles(4);
      n_cmp++;
      if (get_count(1) != 1 || pe_n[1] != p1) begin
         $display("FAIL even_good: Count=%0d PE=%0d, required 1 0", get_count(1), pe_n[1] - p1);
         n_fail++;
      end
      send_frame(1, 9'h0A3, 8, 1, 1'b1, 1'b1);
      wait_cycles(4);
      n_cmp++;
      if (pe_n[1] - p1 != 1 || fe_n[1] != f1) begin
         $display("FAIL even_bad: PE=%0d FE=%0d pulses, required 1 0", pe_n[1] - p1, fe_n[1] - f1);
         n_fail++;
      end
      n_cmp++;
      if (get_count(1) != 1) begin
         $display("FAIL even_bad_count: Count=%0d, required 1", get_count(1));
         n_fail++;
      end
      pop_check(1);
      send_frame(2, 9'h041, 7, 1, 1'b1, 1'b1);
      q2.push_back(9'h041);
      wait_cycles(4);
      n_cmp++;
      if (pe_n[2] != 0 || get_count(2) != 1) begin
         $display("FAIL odd_good: PE=%0d Count=%0d, required 0 1", pe_n[2], get_count(2));
         n_fail++;
      end
      pop_check(2);
   endtask

   task automatic test_glitch_enable();
      int f0 = fe_n[0], p0 = pe_n[0], o0 = ovf_n[0];
      rx[0] = 1'b0;
      wait_cycles(C / 4);
      rx[0] = 1'b1;
      wait_cycles(2 * C);
      n_cmp++;
      if (get_count(0) != 0 || fe_n[0] != f0 || pe_n[0] != p0 || ovf_n[0] != o0) begin
         $display("FAIL glitch: Count=%0d FE=%0d PE=%0d OVF=%0d, required all 0",
                  get_count(0), fe_n[0]-f0, pe_n[0]-p0, ovf_n[0]-o0);
         n_fail++;
      end
      en = 1'b0;
      send_frame(0, 9'h055, 8, 0, 1'b0, 1'b1);
      wait_cycles(4);
      n_cmp++;
      if (get_count(0) != 0 || vld[0] !== 1'b0) begin
         $display("FAIL disabled: Count=%0d Valid=%0b, required 0 0", get_count(0), vld[0]);
         n_fail++;
      end
      en = 1'b1;
      wait_cycles(4);
   endtask

   task automatic test_reset_mid();
      int f0, p0, o0;
      send_frame(0, 9'h011, 8, 0, 1'b0, 1'b1);
      send_frame(0, 9'h022, 8, 0, 1'b0, 1'b1);
      wait_cycles(4);
      n_cmp++;
      if (get_count(0) != 2) begin
         $display("FAIL rst_pre: Count=%0d, required 2", get_count(0));
         n_fail++;
      end
      drive_bit(0, 1'b0);
      for (int i = 0; i < 3; i++) drive_bit(0, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (get_count(0) != 0 || vld[0] !== 1'b0) begin
         $display("FAIL rst_mid: Count=%0d Valid=%0b, required 0 0", get_count(0), vld[0]);
         n_fail++;
      end
      reset = 1'b0;
      rx[0] = 1'b1;
      q0.delete();
      wait_cycles(C);
      f0 = fe_n[0]; p0 = pe_n[0]; o0 = ovf_n[0];
      send_frame(0, 9'h00F, 8, 0, 1'b0, 1'b1);
      q0.push_back(9'h00F);
      wait_cycles(4);
      pop_check(0);
      n_cmp++;
      if (fe_n[0] != f0 || pe_n[0] != p0 || ovf_n[0] != o0) begin
         $display("FAIL rst_after: FE=%0d PE=%0d OVF=%0d pulses, required 0",
                  fe_n[0]-f0, pe_n[0]-p0, ovf_n[0]-o0);
         n_fail++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      rx    = 3'b111;
      en    = 1'b1;
      rdy   = 3'b000;
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_break();
      test_parity();
      test_glitch_enable();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
